// File: rtl/calc_exec_pkg.sv
// Shared definitions for the calculator execute stage: op/key codes, FSM states,
// datapath widths, display segment codes and BCD helpers.
package calc_exec_pkg;

    localparam int OPW  = 7;   // binary operand width, 0..99
    localparam int RESW = 14;  // binary result width, up to 9801
    localparam int NDIG = 4;   // BCD result digits

    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ = 4'he;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ERR   = 7'h79;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_BCD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [OPW-1:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return OPW'(tens) * OPW'(10) + OPW'(ones);
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/calc_exec_if.sv
// Request/result bundle between the entry FSM (master) and calc_exec (slave).
// rem_bcd exists only when CALC_REM_EN is defined.
interface calc_exec_if;
    import calc_exec_pkg::*;

    logic              start;
    logic [3:0]        a_tens;
    logic [3:0]        a_ones;
    logic [3:0]        b_tens;
    logic [3:0]        b_ones;
    logic [3:0]        op;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] res_bcd;
    logic              res_neg;
    logic              res_err;
`ifdef CALC_REM_EN
    logic [7:0]        rem_bcd;
`endif

    modport master (
        output start, a_tens, a_ones, b_tens, b_ones, op,
`ifdef CALC_REM_EN
        input  rem_bcd,
`endif
        input  busy, done, res_bcd, res_neg, res_err
    );

    modport slave (
        input  start, a_tens, a_ones, b_tens, b_ones, op,
`ifdef CALC_REM_EN
        output rem_bcd,
`endif
        output busy, done, res_bcd, res_neg, res_err
    );

endinterface

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble binary to BCD converter, one add-3/shift per clock.
// Latency: WIDTH clocks; the edge that takes start performs the first shift, done pulses after the last.
// Backpressure: start is ignored while a conversion runs; bcd holds until the next start.
module calc_bin2bcd #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    logic [WIDTH-1:0] sh_q, src_sh, nxt_sh;
    logic [BW-1:0]    bcd_q, src_bcd, adj, nxt_bcd;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q, take;

    assign take = start && !run_q;

    // A new request is shifted straight from bin so no load cycle is spent.
    always_comb begin
        src_sh  = take ? bin : sh_q;
        src_bcd = take ? '0 : bcd_q;
        adj     = src_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        nxt_bcd = (adj << 1) | BW'(src_sh[WIDTH-1]);
        nxt_sh  = src_sh << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (take) begin
                sh_q  <= nxt_sh;
                bcd_q <= nxt_bcd;
                cnt_q <= CW'(WIDTH - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                sh_q  <= nxt_sh;
                bcd_q <= nxt_bcd;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_exec.sv
// Calculator execute stage: BCD operands -> + - * / -> 4 BCD digits with sign/error (CALC_REM_EN adds rem_bcd).
// Latency: done after edge 17 for + - *, edge 23 for /, edge 3 on error (edge 1 samples start).
// Backpressure: start is only taken while busy=0 and never queued; results hold until the next done.
module calc_exec
    import calc_exec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    calc_exec_if.slave bus
);
    localparam int REMW = OPW + 1;

    state_t state_q, state_nxt;

    logic [3:0]        a_tens_q, a_ones_q, b_tens_q, b_ones_q, op_q;
    logic [OPW-1:0]    a_val, b_val, a_q, b_q, quo_q, quo_nxt;
    logic [REMW-1:0]   rem_q, rem_sh, rem_nxt;
    logic [2:0]        div_cnt_q;
    logic              fits, last_div, in_err, err_q, neg_q;
    logic [RESW-1:0]   res_bin;
    logic              conv_start, conv_done;
    logic [4*NDIG-1:0] conv_bcd, res_bcd_q;
    logic              res_neg_q, res_err_q, busy, done;

    assign a_val  = bcd2bin(a_tens_q, a_ones_q);
    assign b_val  = bcd2bin(b_tens_q, b_ones_q);
    assign in_err = digit_bad(a_tens_q) || digit_bad(a_ones_q) ||
                    digit_bad(b_tens_q) || digit_bad(b_ones_q) ||
                    (op_q < OP_ADD) || (op_q > OP_DIV) ||
                    ((op_q == OP_DIV) && (b_tens_q == 4'd0) && (b_ones_q == 4'd0));

    // Restoring divider: one quotient bit per CALC cycle, MSB first.
    assign rem_sh   = (rem_q << 1) | REMW'(quo_q[OPW-1]);
    assign fits     = rem_sh >= {1'b0, b_q};
    assign rem_nxt  = fits ? rem_sh - {1'b0, b_q} : rem_sh;
    assign quo_nxt  = (quo_q << 1) | OPW'(fits);
    assign last_div = div_cnt_q == 3'(OPW - 1);

    always_comb begin
        res_bin = '0;
        case (op_q)
            OP_ADD:  res_bin = RESW'(a_q) + RESW'(b_q);
            OP_SUB:  res_bin = neg_q ? RESW'(b_q) - RESW'(a_q) : RESW'(a_q) - RESW'(b_q);
            OP_MUL:  res_bin = RESW'(a_q) * RESW'(b_q);
            OP_DIV:  res_bin = RESW'(quo_nxt);
            default: res_bin = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CALC;
            ST_CALC: begin
                if (err_q)           state_nxt = ST_DONE;
                else if (conv_start) state_nxt = ST_BCD;
            end
            ST_BCD:  if (conv_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q != ST_IDLE;
        done       = state_q == ST_DONE;
        conv_start = (state_q == ST_CALC) && !err_q && ((op_q != OP_DIV) || last_div);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_tens_q  <= '0;
            a_ones_q  <= '0;
            b_tens_q  <= '0;
            b_ones_q  <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_cnt_q <= '0;
            err_q     <= 1'b0;
            neg_q     <= 1'b0;
            res_bcd_q <= '0;
            res_neg_q <= 1'b0;
            res_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_tens_q <= bus.a_tens;
                        a_ones_q <= bus.a_ones;
                        b_tens_q <= bus.b_tens;
                        b_ones_q <= bus.b_ones;
                        op_q     <= bus.op;
                    end
                end
                ST_LOAD: begin
                    a_q       <= a_val;
                    b_q       <= b_val;
                    quo_q     <= a_val;
                    rem_q     <= '0;
                    div_cnt_q <= '0;
                    err_q     <= in_err;
                    neg_q     <= (op_q == OP_SUB) && (a_val < b_val);
                end
                ST_CALC: begin
                    if (op_q == OP_DIV) begin
                        quo_q     <= quo_nxt;
                        rem_q     <= rem_nxt;
                        div_cnt_q <= div_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
            // Visible results change only on the edge that enters DONE.
            if (state_nxt == ST_DONE) begin
                res_bcd_q <= err_q ? '0 : conv_bcd;
                res_neg_q <= neg_q && !err_q;
                res_err_q <= err_q;
            end
        end
    end

    calc_bin2bcd #(
        .WIDTH  (RESW),
        .DIGITS (NDIG)
    ) u_res_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (res_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

`ifdef CALC_REM_EN
    logic [7:0] rem_conv_bcd, rem_bcd_q;
    logic       rem_done, rem_vld_q;

    calc_bin2bcd #(
        .WIDTH  (OPW),
        .DIGITS (2)
    ) u_rem_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (rem_nxt[OPW-1:0]),
        .done  (rem_done),
        .bcd   (rem_conv_bcd)
    );

    // The shorter remainder conversion finishes first; remember that it did.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_vld_q <= 1'b0;
            rem_bcd_q <= '0;
        end else begin
            if (conv_start)    rem_vld_q <= 1'b0;
            else if (rem_done) rem_vld_q <= 1'b1;
            if (state_nxt == ST_DONE)
                rem_bcd_q <= ((op_q == OP_DIV) && !err_q && rem_vld_q) ? rem_conv_bcd : '0;
        end
    end

    assign bus.rem_bcd = rem_bcd_q;
`endif

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.res_bcd = res_bcd_q;
    assign bus.res_neg = res_neg_q;
    assign bus.res_err = res_err_q;

endmodule
